// File: rtl/nv_ram_rws_64x18_fifo_ctrl.sv
// nv_ram_rws_64x18_fifo_ctrl
//
// Flow-controlled 64-entry x 18-bit FIFO controller. The storage is an external
// nv_ram_rws_64x18 instance in the parent. This block drives the RAM write port
// and captures the read address in the RAM. The RAM's combinational output
// (ram_dout) is the head payload of the read stream.
//
// Ports:
//   nvdla_core_clk   clock; all state changes on its rising edge
//   nvdla_core_rstn  asynchronous active-low reset
//   wr_pvld/wr_prdy/wr_pd   write stream (18-bit payload)
//   rd_pvld/rd_prdy/rd_pd   read stream; rd_pd is ram_dout
//   wr_count         occupancy 0..64, including the displayed head entry
//   wr_afull         occupancy >= AFULL_THRESH
//   idle             empty and no write being accepted this cycle
//   ram_we/ram_wa/ram_di    RAM write port
//   ram_re/ram_ra           RAM read-address capture port
//   ram_dout         RAM read data from its registered read address
//
// Parameter:
//   AFULL_THRESH     almost-full level, legal range 1..64

module nv_ram_rws_64x18_fifo_ctrl #(
  parameter int unsigned AFULL_THRESH = 60
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rstn,
  input  logic        wr_pvld,
  output logic        wr_prdy,
  input  logic [17:0] wr_pd,
  output logic        rd_pvld,
  input  logic        rd_prdy,
  output logic [17:0] rd_pd,
  output logic [6:0]  wr_count,
  output logic        wr_afull,
  output logic        idle,
  output logic        ram_we,
  output logic [5:0]  ram_wa,
  output logic [17:0] ram_di,
  output logic        ram_re,
  output logic [5:0]  ram_ra,
  input  logic [17:0] ram_dout
);

  localparam logic [6:0] FULL_LVL  = 7'd64;
  localparam logic [6:0] AFULL_LVL = 7'(AFULL_THRESH);

  // State
  logic [5:0] wr_ptr_reg;
  logic [5:0] rd_ptr_reg;
  logic [6:0] occ_reg;    // entries held, including the displayed head
  logic [6:0] pend_reg;   // entries written but not yet fetched
  logic       out_vld_reg;

  logic [5:0] wr_ptr_next;
  logic [5:0] rd_ptr_next;
  logic [6:0] occ_next;
  logic [6:0] pend_next;
  logic       out_vld_next;

  logic accept;
  logic pop;
  logic fetch;

  // A full FIFO refuses writes even when a pop happens in the same cycle.
  // This keeps wr_prdy a pure register decode, with no path from rd_prdy.
  assign wr_prdy = (occ_reg != FULL_LVL);

  // The reset term blocks RAM writes and fetches while reset is held.
  assign accept = wr_pvld & wr_prdy & nvdla_core_rstn;
  assign pop    = out_vld_reg & rd_prdy;

  // Fetch when the read-address register is empty or is being freed by a pop.
  // A stalled head (out_vld & !pop) blocks any fetch, so rd_pd stays stable.
  assign fetch  = (pend_reg != 7'd0) & (~out_vld_reg | pop) & nvdla_core_rstn;

  always_comb begin
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    occ_next     = occ_reg + {6'd0, accept} - {6'd0, pop};
    pend_next    = pend_reg + {6'd0, accept} - {6'd0, fetch};
    out_vld_next = fetch | (out_vld_reg & ~pop);
    if (accept) begin
      wr_ptr_next = wr_ptr_reg + 6'd1;   // wraps 63 -> 0
    end
    if (fetch) begin
      rd_ptr_next = rd_ptr_reg + 6'd1;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr_reg  <= 6'd0;
      rd_ptr_reg  <= 6'd0;
      occ_reg     <= 7'd0;
      pend_reg    <= 7'd0;
      out_vld_reg <= 1'b0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      occ_reg     <= occ_next;
      pend_reg    <= pend_next;
      out_vld_reg <= out_vld_next;
    end
  end

  // RAM ports. The write address and data are shown at all times; ram_we
  // qualifies them. ram_ra always shows the next entry to fetch.
  assign ram_we = accept;
  assign ram_wa = wr_ptr_reg;
  assign ram_di = wr_pd;
  assign ram_re = fetch;
  assign ram_ra = rd_ptr_reg;

  // Read stream and status
  assign rd_pvld  = out_vld_reg;
  assign rd_pd    = ram_dout;
  assign wr_count = occ_reg;
  assign wr_afull = (occ_reg >= AFULL_LVL);
  assign idle     = (occ_reg == 7'd0) & ~accept;

endmodule

// File: tb/tb_nv_ram_rws_64x18_fifo_ctrl.sv
// Testbench for nv_ram_rws_64x18_fifo_ctrl. It includes a model of the external
// RAM: writes are synchronous, the read address is registered, and the read
// data is combinational. The expected behaviour comes from a queue model of
// FIFO contents.

module tb_nv_ram_rws_64x18_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wr_pvld;
  logic        wr_prdy;
  logic [17:0] wr_pd;
  logic        rd_pvld;
  logic        rd_prdy;
  logic [17:0] rd_pd;
  logic [6:0]  wr_count;
  logic        wr_afull;
  logic        idle;
  logic        ram_we;
  logic [5:0]  ram_wa;
  logic [17:0] ram_di;
  logic        ram_re;
  logic [5:0]  ram_ra;
  logic [17:0] ram_dout;

  always #5 clk = ~clk;

  nv_ram_rws_64x18_fifo_ctrl #(.AFULL_THRESH(60)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .wr_pvld        (wr_pvld),
    .wr_prdy        (wr_prdy),
    .wr_pd          (wr_pd),
    .rd_pvld        (rd_pvld),
    .rd_prdy        (rd_prdy),
    .rd_pd          (rd_pd),
    .wr_count       (wr_count),
    .wr_afull       (wr_afull),
    .idle           (idle),
    .ram_we         (ram_we),
    .ram_wa         (ram_wa),
    .ram_di         (ram_di),
    .ram_re         (ram_re),
    .ram_ra         (ram_ra),
    .ram_dout       (ram_dout)
  );

  // External RAM model
  logic [17:0] mem [0:63];
  logic [5:0]  ra_q;
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ra_q <= ram_ra;
  end
  assign ram_dout = mem[ra_q];

  // Reference model: FIFO contents in order, plus the write address
  logic [17:0] q[$];
  int unsigned wa_model;
  int unsigned starve;
  int unsigned pops;
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check one cycle against the model, take the clock edge, and update the model.
  task automatic tick();
    logic        acc;
    logic        pp;
    logic        stall;
    logic [17:0] hold;
    logic [17:0] din;
    #1;
    acc = wr_pvld && (q.size() != 64);
    pp  = rd_pvld && rd_prdy;
    din = wr_pd;
    chk("count", 32'(wr_count), 32'(q.size()));
    chk("wr_prdy", 32'(wr_prdy), 32'(q.size() != 64));
    chk("wr_afull", 32'(wr_afull), 32'(q.size() >= 60));
    chk("ram_we", 32'(ram_we), 32'(acc));
    chk("idle", 32'(idle), 32'((q.size() == 0) && !acc));
    if (acc) begin
      chk("ram_wa", 32'(ram_wa), wa_model);
      chk("ram_di", 32'(ram_di), 32'(din));
    end
    if (rd_pvld) begin
      chk("pvld_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) chk("rd_pd", 32'(rd_pd), 32'(q[0]));
    end
    if (q.size() != 0 && !rd_pvld) starve++; else starve = 0;
    chk("fetch_latency", 32'(starve <= 1), 32'd1);
    stall = rd_pvld && !rd_prdy;
    hold  = rd_pd;
    @(posedge clk);
    #1;
    if (pp && q.size() != 0) begin
      void'(q.pop_front());
      pops++;
    end
    if (acc) begin
      q.push_back(din);
      wa_model = (wa_model + 1) % 64;
    end
    if (stall) begin
      chk("stall_vld", 32'(rd_pvld), 32'd1);
      chk("stall_pd", 32'(rd_pd), 32'(hold));
    end
  endtask

  task automatic do_reset();
    rstn    = 1'b0;
    wr_pvld = 1'b0;
    rd_prdy = 1'b0;
    wr_pd   = '0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    q.delete();
    wa_model = 0;
    starve   = 0;
  endtask

  task automatic drain(input int budget);
    int n;
    wr_pvld = 1'b0;
    rd_prdy = 1'b1;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(wr_count), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    wa_model = 0;
    starve   = 0;
    pops     = 0;

    // Reset. wr_pvld is held high to show that no write occurs during reset.
    rstn    = 1'b0;
    wr_pvld = 1'b1;
    wr_pd   = 18'h3FFFF;
    rd_prdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_re", 32'(ram_re), 32'd0);
    chk("rst_prdy", 32'(wr_prdy), 32'd1);
    chk("rst_idle", 32'(idle), 32'd1);
    rstn    = 1'b1;
    wr_pvld = 1'b0;
    #1;
    chk("rel_pvld", 32'(rd_pvld), 32'd0);
    chk("rel_prdy", 32'(wr_prdy), 32'd1);
    chk("rel_count", 32'(wr_count), 32'd0);
    chk("rel_idle", 32'(idle), 32'd1);
    chk("rel_afull", 32'(wr_afull), 32'd0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("quiet_re", 32'(ram_re), 32'd0);
      tick();
    end

    // Single entry: check the fetch cycle and the display latency.
    wr_pvld = 1'b1;
    wr_pd   = 18'h2A5A5;
    rd_prdy = 1'b1;
    #1;
    chk("se_we", 32'(ram_we), 32'd1);
    chk("se_re_early", 32'(ram_re), 32'd0);
    tick();
    wr_pvld = 1'b0;
    #1;
    chk("se_re", 32'(ram_re), 32'd1);
    chk("se_ra", 32'(ram_ra), 32'd0);
    chk("se_pvld_early", 32'(rd_pvld), 32'd0);
    tick();
    chk("se_pvld", 32'(rd_pvld), 32'd1);
    chk("se_pd", 32'(rd_pd), 32'h2A5A5);
    tick();
    chk("se_count", 32'(wr_count), 32'd0);
    chk("se_empty", 32'(rd_pvld), 32'd0);

    // Fill to full with payloads 0..63 and no reads.
    do_reset();
    rd_prdy = 1'b0;
    for (int i = 0; i < 64; i++) begin
      wr_pvld = 1'b1;
      wr_pd   = 18'(i);
      #1;
      chk("fill_wa", 32'(ram_wa), 32'(i));
      chk("fill_afull", 32'(wr_afull), 32'(i >= 60));
      tick();
    end
    chk("full_prdy", 32'(wr_prdy), 32'd0);
    chk("full_count", 32'(wr_count), 32'd64);
    chk("full_afull", 32'(wr_afull), 32'd1);
    wr_pd = 18'h3FFFF;
    #1;
    chk("full_refuse", 32'(ram_we), 32'd0);
    tick();
    chk("full_count2", 32'(wr_count), 32'd64);
    chk("full_head", 32'(rd_pd), 32'd0);

    // Drain from full. The first pop happens with wr_pvld still high.
    // No write may occur at full.
    rd_prdy = 1'b1;
    pops = 0;
    for (int i = 0; i < 64; i++) begin
      wr_pvld = (i == 0);
      #1;
      chk("drain_we", 32'(ram_we), 32'd0);
      chk("drain_pvld", 32'(rd_pvld), 32'd1);
      chk("drain_pd", 32'(rd_pd), 32'(i));
      tick();
    end
    chk("drain_pops", pops, 32'd64);
    chk("drain_count", 32'(wr_count), 32'd0);

    // Write addresses wrap to 0.
    wr_pvld = 1'b1;
    rd_prdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_pd = 18'($urandom);
      #1;
      chk("wrap_wa", 32'(ram_wa), 32'(i));
      tick();
    end
    pops = 0;
    drain(40);
    chk("wrap_pops", pops, 32'd10);

    // Concurrent streaming with an incrementing payload
    pops    = 0;
    wr_pvld = 1'b1;
    rd_prdy = 1'b1;
    for (int k = 0; k < 200; k++) begin
      wr_pd = 18'(k);
      tick();
      chk("stream_count", 32'(wr_count <= 7'd2), 32'd1);
    end
    chk("stream_pops", pops, 32'd198);
    drain(10);

    // Random traffic with backpressure
    for (int i = 0; i < 300; i++) begin
      wr_pvld = 1'($urandom_range(0, 1));
      rd_prdy = 1'($urandom_range(0, 1));
      wr_pd   = 18'($urandom);
      tick();
    end

    // Bias toward filling, then reset at occupancy 37.
    n = 0;
    while (q.size() != 37 && n < 2000) begin
      wr_pvld = ($urandom_range(0, 3) != 0);
      rd_prdy = ($urandom_range(0, 3) == 0);
      wr_pd   = 18'($urandom);
      tick();
      n++;
    end
    chk("reach37", 32'(wr_count), 32'd37);
    #2;
    wr_pvld = 1'b1;
    rstn    = 1'b0;
    #1;
    chk("arst_pvld", 32'(rd_pvld), 32'd0);
    chk("arst_prdy", 32'(wr_prdy), 32'd1);
    chk("arst_count", 32'(wr_count), 32'd0);
    chk("arst_afull", 32'(wr_afull), 32'd0);
    chk("arst_idle", 32'(idle), 32'd1);
    chk("arst_we", 32'(ram_we), 32'd0);
    chk("arst_re", 32'(ram_re), 32'd0);
    q.delete();
    wa_model = 0;
    starve   = 0;
    @(posedge clk);
    #1;
    chk("arst_hold_count", 32'(wr_count), 32'd0);
    chk("arst_hold_we", 32'(ram_we), 32'd0);
    rstn    = 1'b1;
    wr_pvld = 1'b0;

    // After reset, one more entry goes through.
    wr_pvld = 1'b1;
    wr_pd   = 18'h15A5A;
    rd_prdy = 1'b1;
    #1;
    chk("post_wa", 32'(ram_wa), 32'd0);
    tick();
    pops = 0;
    drain(10);
    chk("post_pops", pops, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
